// File: rtl/resiz_cycle_seq.sv
// Bus cycle sequencer for SRAM/COM peripherals behind the 68150 dynamic bus resizer.
// Counts wait states and DSACK length per resizer beat and aborts stalled strobes.
module resiz_cycle_seq #(
  parameter int RAM_WAIT = 5,
  parameter int COM_WAIT = 9,
  parameter int ACK_LEN  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       target,
  input  logic [1:0] siz,
  input  logic       resiz_ds_n,
  output logic       resiz_cs,
  output logic       ram_cs,
  output logic       com_cs,
  output logic [1:0] dsack_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, WAIT_DS, COUNT, ACK, RELEASE, DONE, ERR} state_t;

  localparam logic [7:0] RAM_LAST = (RAM_WAIT > 0) ? 8'(RAM_WAIT - 1) : 8'd0;
  localparam logic [7:0] COM_LAST = (COM_WAIT > 0) ? 8'(COM_WAIT - 1) : 8'd0;
  localparam logic [7:0] ACK_LAST = (ACK_LEN > 1) ? 8'(ACK_LEN - 1) : 8'd0;
  localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);

  state_t     state;
  logic       tgt;
  logic [2:0] beats;
  logic [7:0] tmo;
  logic [7:0] wcnt;
  logic [7:0] acnt;

  logic [2:0] start_beats;
  logic       start_illegal;
  logic       wait_zero;
  logic [7:0] wait_last;
  logic [7:0] tmo_inc;
  logic       tmo_hit;
  logic [1:0] ack_code;

  // Beats needed to move the CPU operand through the port; the 8-bit port cannot carry a line.
  always_comb begin
    start_illegal = 1'b0;
    case (siz)
      2'b00:   start_beats = target ? 3'd4 : 3'd2;
      2'b01:   start_beats = 3'd1;
      2'b10:   start_beats = target ? 3'd2 : 3'd1;
      default: begin
        start_beats   = 3'd2;
        start_illegal = target;
      end
    endcase
  end

  assign wait_zero = tgt ? (COM_WAIT == 0) : (RAM_WAIT == 0);
  assign wait_last = tgt ? COM_LAST : RAM_LAST;
  assign tmo_inc   = (tmo == 8'hFF) ? tmo : tmo + 8'd1;
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_inc == TMO_LIM);
  assign ack_code  = tgt ? 2'b10 : 2'b01;

  assign ram_cs = resiz_cs & ~tgt & ~resiz_ds_n;
  assign com_cs = resiz_cs &  tgt & ~resiz_ds_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tgt      <= 1'b0;
      beats    <= 3'd0;
      tmo      <= 8'd0;
      wcnt     <= 8'd0;
      acnt     <= 8'd0;
      resiz_cs <= 1'b0;
      dsack_n  <= 2'b11;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tgt   <= target;
            beats <= start_beats;
            tmo   <= 8'd0;
            busy  <= 1'b1;
            if (start_illegal) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state    <= WAIT_DS;
              resiz_cs <= 1'b1;
            end
          end
        end
        WAIT_DS: begin
          if (!resiz_ds_n) begin
            wcnt <= 8'd0;
            acnt <= 8'd0;
            if (wait_zero) begin
              state   <= ACK;
              dsack_n <= ack_code;
            end else begin
              state <= COUNT;
            end
          end else begin
            tmo <= tmo_inc;
            if (tmo_hit) begin
              state    <= ERR;
              resiz_cs <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        COUNT: begin
          if (wcnt == wait_last) begin
            state   <= ACK;
            acnt    <= 8'd0;
            dsack_n <= ack_code;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        ACK: begin
          if (acnt == ACK_LAST) begin
            state   <= RELEASE;
            tmo     <= 8'd0;
            dsack_n <= 2'b11;
          end else begin
            acnt <= acnt + 8'd1;
          end
        end
        // The strobe level seen here is what ends the beat, regardless of earlier toggles.
        RELEASE: begin
          if (resiz_ds_n) begin
            beats <= beats - 3'd1;
            if (beats <= 3'd1) begin
              state    <= DONE;
              resiz_cs <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= WAIT_DS;
              tmo   <= 8'd0;
            end
          end else begin
            tmo <= tmo_inc;
            if (tmo_hit) begin
              state    <= ERR;
              resiz_cs <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          resiz_cs <= 1'b0;
          dsack_n  <= 2'b11;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resiz_cycle_seq.sv
// Directed bench for resiz_cycle_seq with a simple resizer strobe model.
module tb_resiz_cycle_seq;

  // {resiz_cs, ram_cs, com_cs, dsack_n[1:0], busy, done, err} with everything at rest
  localparam logic [7:0] REST = 8'b0001_1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       target = 1'b0;
  logic [1:0] siz = 2'b00;
  logic       resiz_ds_n = 1'b1;
  logic       resiz_cs, ram_cs, com_cs, busy, done, err;
  logic [1:0] dsack_n;

  int assert_count = 0;
  int fail_count   = 0;

  resiz_cycle_seq dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .siz(siz),
    .resiz_ds_n(resiz_ds_n), .resiz_cs(resiz_cs), .ram_cs(ram_cs), .com_cs(com_cs),
    .dsack_n(dsack_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] status();
    return {resiz_cs, ram_cs, com_cs, dsack_n, busy, done, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    assert_count++;
    if (got != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic applyStimulus(input logic tgt, input logic [1:0] sz);
    target = tgt;
    siz    = sz;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Resizer model: strobe low right after start, release one clock after each ack window,
  // strobe again one clock later while beats remain.
  task automatic runTransfer(input string tag, input logic tgt, input logic [1:0] sz,
                             input int exp_beats, input int exp_lat, input int exp_done,
                             input int glitch_cyc);
    int cyc = 0;
    int low_at = 0;
    int ack_at = -1;
    int rel_at = -1;
    int wins = 0;
    int done_at = -1;
    int errs = 0;
    int cs_bad = 0;
    int busy_bad = 0;
    logic [1:0] exp_code;
    logic [2:0] exp_cs;
    exp_code = tgt ? 2'b10 : 2'b01;
    applyStimulus(tgt, sz);
    while (1) begin
      if (err) errs++;
      if (!busy) busy_bad++;
      if (dsack_n != 2'b11) begin
        if (ack_at < 0) begin
          ack_at = cyc;
          checkOutput({tag, " ack latency"}, cyc - low_at, exp_lat);
          checkOutput({tag, " ack code"}, int'(dsack_n), int'(exp_code));
        end
      end else if (ack_at >= 0) begin
        checkOutput({tag, " ack width"}, cyc - ack_at, 2);
        ack_at = -1;
        wins++;
        rel_at = cyc + 1;
      end
      if (done) begin
        done_at = cyc;
        break;
      end
      if (cyc >= 400) break;
      if (cyc == rel_at) begin
        resiz_ds_n = 1'b1;
      end else if (cyc == rel_at + 1 && wins < exp_beats) begin
        resiz_ds_n = 1'b0;
        low_at = cyc;
      end
      if (cyc == glitch_cyc) begin
        start  = 1'b1;
        target = ~tgt;
        siz    = 2'b01;
      end else begin
        start  = 1'b0;
        target = tgt;
        siz    = sz;
      end
      #1;
      exp_cs = {1'b1, ~tgt & ~resiz_ds_n, tgt & ~resiz_ds_n};
      if ({resiz_cs, ram_cs, com_cs} != exp_cs) cs_bad++;
      tick();
      cyc++;
    end
    start = 1'b0;
    resiz_ds_n = 1'b1;
    checkOutput({tag, " done cycle"}, done_at, exp_done);
    checkOutput({tag, " ack windows"}, wins, exp_beats);
    checkOutput({tag, " err pulses"}, errs, 0);
    checkOutput({tag, " chip select errors"}, cs_bad, 0);
    checkOutput({tag, " busy drops"}, busy_bad, 0);
    tick();
    checkOutput({tag, " rest after done"}, int'(status()), int'(REST));
  endtask

  initial begin
    int cyc;
    int err_at;
    int acks;

    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset state", int'(status()), int'(REST));
    rst = 1'b0;
    tick();
    checkOutput("idle state", int'(status()), int'(REST));

    runTransfer("sram word", 1'b0, 2'b10, 1, 6, 10, -1);
    runTransfer("com long", 1'b1, 2'b00, 4, 10, 56, -1);

    // 8-bit port cannot carry a line: immediate error, no chip select
    applyStimulus(1'b1, 2'b11);
    checkOutput("com line err", int'(status()), int'(8'b0001_1101));
    tick();
    checkOutput("com line rest", int'(status()), int'(REST));

    // Strobe never arrives
    applyStimulus(1'b0, 2'b00);
    cyc = 0;
    err_at = -1;
    acks = 0;
    while (cyc < 300) begin
      if (err) begin
        err_at = cyc;
        break;
      end
      if (dsack_n != 2'b11) acks++;
      tick();
      cyc++;
    end
    checkOutput("timeout err cycle", err_at, 255);
    checkOutput("timeout no dsack", acks, 0);
    checkOutput("timeout cs/dsack at err", int'({resiz_cs, dsack_n}), 3);
    tick();
    checkOutput("timeout rest", int'(status()), int'(REST));
    runTransfer("after timeout", 1'b0, 2'b10, 1, 6, 10, -1);

    // Reset while the first beat of an SRAM long is acknowledging
    applyStimulus(1'b0, 2'b00);
    resiz_ds_n = 1'b0;
    cyc = 0;
    while (dsack_n == 2'b11 && cyc < 20) begin
      tick();
      cyc++;
    end
    checkOutput("reset test reached ack", int'(dsack_n), 1);
    rst = 1'b1;
    tick();
    checkOutput("reset mid beat", int'(status()), int'(REST));
    rst = 1'b0;
    resiz_ds_n = 1'b1;
    tick();
    checkOutput("after reset no pulse", int'(status()), int'(REST));
    runTransfer("after reset", 1'b0, 2'b10, 1, 6, 10, -1);

    // start (with other target/size) during COUNT must be ignored
    runTransfer("com word glitch", 1'b1, 2'b10, 2, 10, 28, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
